// File: rtl/mux32to1_pkg.sv
// Shared constants for the registered 32:1 word multiplexer.
package mux32to1_pkg;

    localparam int NUM_INPUTS    = 32;
    localparam int SEL_W         = 5;
    localparam int WIDTH_DEFAULT = 32;

    // The select splits into a lane index for the 8:1 banks and a bank index.
    localparam int LANE_SEL_W = 3;
    localparam int BANK_SEL_W = SEL_W - LANE_SEL_W;
    localparam int NUM_BANKS  = NUM_INPUTS >> LANE_SEL_W;

endpackage

// File: rtl/mux_8to1.sv
// Combinational 8:1 word multiplexer; one bank of the 32:1 selector.
module mux_8to1
    import mux32to1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0]      d0,
    input  logic [WIDTH-1:0]      d1,
    input  logic [WIDTH-1:0]      d2,
    input  logic [WIDTH-1:0]      d3,
    input  logic [WIDTH-1:0]      d4,
    input  logic [WIDTH-1:0]      d5,
    input  logic [WIDTH-1:0]      d6,
    input  logic [WIDTH-1:0]      d7,
    input  logic [LANE_SEL_W-1:0] sel,
    output logic [WIDTH-1:0]      y
);

    always_comb begin
        y = d0;
        case (sel)
            3'd0:    y = d0;
            3'd1:    y = d1;
            3'd2:    y = d2;
            3'd3:    y = d3;
            3'd4:    y = d4;
            3'd5:    y = d5;
            3'd6:    y = d6;
            default: y = d7;
        endcase
    end

endmodule

// File: rtl/mux_32_to_1.sv
// Registered 32:1 word multiplexer built from four 8:1 banks and a 4:1 stage.
// Define MUX32TO1_LOAD_EN to add the load_en output update enable.
module mux_32_to_1
    import mux32to1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] reg0,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [WIDTH-1:0] reg3,
    input  logic [WIDTH-1:0] reg4,
    input  logic [WIDTH-1:0] reg5,
    input  logic [WIDTH-1:0] reg6,
    input  logic [WIDTH-1:0] reg7,
    input  logic [WIDTH-1:0] reg8,
    input  logic [WIDTH-1:0] reg9,
    input  logic [WIDTH-1:0] reg10,
    input  logic [WIDTH-1:0] reg11,
    input  logic [WIDTH-1:0] reg12,
    input  logic [WIDTH-1:0] reg13,
    input  logic [WIDTH-1:0] reg14,
    input  logic [WIDTH-1:0] reg15,
    input  logic [WIDTH-1:0] reg16,
    input  logic [WIDTH-1:0] reg17,
    input  logic [WIDTH-1:0] reg18,
    input  logic [WIDTH-1:0] reg19,
    input  logic [WIDTH-1:0] reg20,
    input  logic [WIDTH-1:0] reg21,
    input  logic [WIDTH-1:0] reg22,
    input  logic [WIDTH-1:0] reg23,
    input  logic [WIDTH-1:0] reg24,
    input  logic [WIDTH-1:0] reg25,
    input  logic [WIDTH-1:0] reg26,
    input  logic [WIDTH-1:0] reg27,
    input  logic [WIDTH-1:0] reg28,
    input  logic [WIDTH-1:0] reg29,
    input  logic [WIDTH-1:0] reg30,
    input  logic [WIDTH-1:0] reg31,
    input  logic [4:0]       select,
`ifdef MUX32TO1_LOAD_EN
    input  logic             load_en,
`endif
    output logic [WIDTH-1:0] regout
);

    logic [WIDTH-1:0] regs      [NUM_INPUTS];
    logic [WIDTH-1:0] bank_word [NUM_BANKS];
    logic [WIDTH-1:0] sel_word_p0;

    assign regs[0]  = reg0;
    assign regs[1]  = reg1;
    assign regs[2]  = reg2;
    assign regs[3]  = reg3;
    assign regs[4]  = reg4;
    assign regs[5]  = reg5;
    assign regs[6]  = reg6;
    assign regs[7]  = reg7;
    assign regs[8]  = reg8;
    assign regs[9]  = reg9;
    assign regs[10] = reg10;
    assign regs[11] = reg11;
    assign regs[12] = reg12;
    assign regs[13] = reg13;
    assign regs[14] = reg14;
    assign regs[15] = reg15;
    assign regs[16] = reg16;
    assign regs[17] = reg17;
    assign regs[18] = reg18;
    assign regs[19] = reg19;
    assign regs[20] = reg20;
    assign regs[21] = reg21;
    assign regs[22] = reg22;
    assign regs[23] = reg23;
    assign regs[24] = reg24;
    assign regs[25] = reg25;
    assign regs[26] = reg26;
    assign regs[27] = reg27;
    assign regs[28] = reg28;
    assign regs[29] = reg29;
    assign regs[30] = reg30;
    assign regs[31] = reg31;

    // Stage p0: lane select inside each bank, then bank select
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mux_8to1 #(.WIDTH(WIDTH)) u_mux_8to1 (
            .d0  (regs[8*g+0]),
            .d1  (regs[8*g+1]),
            .d2  (regs[8*g+2]),
            .d3  (regs[8*g+3]),
            .d4  (regs[8*g+4]),
            .d5  (regs[8*g+5]),
            .d6  (regs[8*g+6]),
            .d7  (regs[8*g+7]),
            .sel (select[LANE_SEL_W-1:0]),
            .y   (bank_word[g])
        );
    end

    always_comb begin
        sel_word_p0 = bank_word[0];
        case (select[SEL_W-1:LANE_SEL_W])
            2'd0:    sel_word_p0 = bank_word[0];
            2'd1:    sel_word_p0 = bank_word[1];
            2'd2:    sel_word_p0 = bank_word[2];
            default: sel_word_p0 = bank_word[3];
        endcase
    end

    // Stage p1: output register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regout <= '0;
`ifdef MUX32TO1_LOAD_EN
        end else if (load_en) begin
`else
        end else begin
`endif
            regout <= sel_word_p0;
        end
    end

endmodule

// File: tb/tb_mux_32_to_1.sv
// Randomized self-checking bench for mux_32_to_1 against an array reference model.
// Exercises the load_en path too when MUX32TO1_LOAD_EN is defined.
module tb_mux_32_to_1;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  data [32];
    logic [4:0]    select = 5'd0;
    logic [W-1:0]  regout;
`ifdef MUX32TO1_LOAD_EN
    logic          load_en = 1'b1;
`endif

    logic [W-1:0]  model;
    int            n_checks = 0;
    int            n_errors = 0;
    int            seq [7] = '{1, 4, 5, 7, 21, 14, 3};

    always #5 clk = ~clk;

    mux_32_to_1 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .reg0   (data[0]),  .reg1  (data[1]),  .reg2  (data[2]),  .reg3  (data[3]),
        .reg4   (data[4]),  .reg5  (data[5]),  .reg6  (data[6]),  .reg7  (data[7]),
        .reg8   (data[8]),  .reg9  (data[9]),  .reg10 (data[10]), .reg11 (data[11]),
        .reg12  (data[12]), .reg13 (data[13]), .reg14 (data[14]), .reg15 (data[15]),
        .reg16  (data[16]), .reg17 (data[17]), .reg18 (data[18]), .reg19 (data[19]),
        .reg20  (data[20]), .reg21 (data[21]), .reg22 (data[22]), .reg23 (data[23]),
        .reg24  (data[24]), .reg25 (data[25]), .reg26 (data[26]), .reg27 (data[27]),
        .reg28  (data[28]), .reg29 (data[29]), .reg30 (data[30]), .reg31 (data[31]),
        .select (select),
`ifdef MUX32TO1_LOAD_EN
        .load_en(load_en),
`endif
        .regout (regout)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Step past the next rising edge; inputs changed afterwards land on the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_identity();
        for (int i = 0; i < 32; i++) data[i] = W'(i);
    endtask

    initial begin
        load_identity();
        select = 5'd9;

        // Reset asserted between edges clears the output at once and holds it.
        #2 rst_n = 1'b0;
        #1 chk("rst_immediate", regout, '0);
        tick();
        chk("rst_hold0", regout, '0);
        select = 5'd20;
        data[20] = 32'h1234_5678;
        tick();
        chk("rst_hold1", regout, '0);
        select = 5'd9;
        data[20] = W'(20);
        tick();
        chk("rst_hold2", regout, '0);

        // First edge after release loads the selected word.
        rst_n = 1'b1;
        tick();
        chk("rst_release_load", regout, 32'd9);

        for (int i = 0; i < 7; i++) begin
            select = 5'(seq[i]);
            #2 chk("no_comb_path", regout, (i == 0) ? 32'd9 : W'(seq[i-1]));
            tick();
            chk("seq", regout, W'(seq[i]));
        end

        data[0] = 32'hDEAD_BEEF;
        data[31] = 32'hFFFF_FFFF;
        select = 5'd0;
        tick();
        chk("sel_min", regout, 32'hDEAD_BEEF);
        select = 5'd31;
        tick();
        chk("sel_max", regout, 32'hFFFF_FFFF);
        load_identity();

        // Held select: only the selected word matters.
        select = 5'd5;
        tick();
        chk("hold_sel5", regout, 32'd5);
        data[5] = 32'h0000_ABCD;
        data[6] = 32'hFFFF_0000;
        #2 chk("sel5_not_yet", regout, 32'd5);
        tick();
        chk("sel5_follow", regout, 32'h0000_ABCD);
        for (int i = 0; i < 4; i++) begin
            data[6] = ~data[6];
            tick();
            chk("nonsel_toggle", regout, 32'h0000_ABCD);
        end
        load_identity();

        // Reset pulse between edges discards the held value.
        select = 5'd21;
        tick();
        chk("pre_pulse", regout, 32'd21);
        #1 rst_n = 1'b0;
        #1 chk("pulse_clear", regout, '0);
        select = 5'd17;
        #1 rst_n = 1'b1;
        #1 chk("pulse_hold", regout, '0);
        tick();
        chk("pulse_reload", regout, 32'd17);

`ifdef MUX32TO1_LOAD_EN
        select = 5'd7;
        tick();
        chk("le_base", regout, 32'd7);
        load_en = 1'b0;
        select = 5'd14;
        tick();
        chk("le_hold0", regout, 32'd7);
        tick();
        chk("le_hold1", regout, 32'd7);
        load_en = 1'b1;
        tick();
        chk("le_load", regout, 32'd14);
        load_en = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk("le_rst_override", regout, '0);
        rst_n = 1'b1;
        tick();
        chk("le_hold_after_rst", regout, '0);
`endif

        // Randomized traffic checked against a simple array lookup.
        model = regout;
        for (int i = 0; i < 300; i++) begin
            select = 5'($urandom_range(31, 0));
            for (int k = 0; k < 4; k++) data[$urandom_range(31, 0)] = $urandom;
`ifdef MUX32TO1_LOAD_EN
            load_en = 1'($urandom_range(1, 0));
            if (load_en) model = data[select];
`else
            model = data[select];
`endif
            tick();
            chk("rand", regout, model);
            if ($urandom_range(15, 0) == 0) begin
                rst_n = 1'b0;
                #1 model = '0;
                chk("rand_rst", regout, model);
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_32_to_1.md
MUX_32_TO_1 -- requirements
Module: mux_32_to_1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of every input word and the output.
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports reg0 … reg31, 32 inputs, WIDTH bits each: candidate data words, index equal to port suffix.
REQ-005 The block SHALL have port select, input, 5 bits: unsigned index of the word to forward.
REQ-006 The block SHALL have port regout, output, WIDTH bits: registered selected word.
REQ-007 The block SHALL have port load_en, input, 1 bit, only when MUX32TO1_LOAD_EN is defined: output update enable.

Function
REQ-008 On each rising clk edge with rst_n high, regout SHALL take the value of reg[select] sampled at that edge.
REQ-009 Latency SHALL be exactly one clock from select/data change to regout; no combinational path from any input to regout.
REQ-010 All 32 select values SHALL be legal, 0 → reg0 through 31 → reg31; no out-of-range case exists.
REQ-011 Select and data changing at the same edge SHALL yield the new data of the new selected word after that edge.
REQ-012 Changes on non-selected inputs SHALL NOT affect regout.
REQ-013 Between edges regout SHALL hold its value.

Reset
REQ-014 rst_n low SHALL force regout to all-zero immediately, independent of clk.
REQ-015 While rst_n is low, regout SHALL stay zero regardless of select, data or load_en.
REQ-016 After rst_n deasserts, the first rising edge SHALL load reg[select] per REQ-008; no extra idle cycle.
REQ-017 Reset asserted mid-operation SHALL discard the held value; no state other than regout exists.

Configuration
REQ-018 With macro MUX32TO1_LOAD_EN defined, regout SHALL update per REQ-008 only on edges where load_en is 1, and hold otherwise; reset still overrides.
REQ-019 Without MUX32TO1_LOAD_EN, port load_en SHALL not exist and regout SHALL update on every edge.

Structure
REQ-020 Shared package mux32to1_pkg SHALL hold constants NUM_INPUTS=32, SEL_W=5 and the default WIDTH=32.
REQ-021 Selection SHALL be built from one sub-module, mux_8to1 (combinational, 8 words + 3-bit select), instantiated four times on select[2:0], with a 4:1 stage on select[4:3] in the parent feeding the output register.

Verification
REQ-022 rst_n=0 with reg0..reg31 = 0..31 and select=9 -> regout = 0 immediately and throughout reset.
REQ-023 reg N = N for all N; select sequence 1, 4, 5, 7, 21, 14, 3, one per clock -> regout = 1, 4, 5, 7, 21, 14, 3, each one clock after its select.
REQ-024 select=0 then 31 with reg0=32'hDEADBEEF, reg31=32'hFFFFFFFF -> regout = DEADBEEF then FFFFFFFF (boundary indices).
REQ-025 select=5 held, reg5 changes 5→32'h0000ABCD while reg6 toggles -> regout follows reg5 one clock later only; reg6 toggles have no effect.
REQ-026 rst_n pulsed low between clock edges while regout=21 -> regout = 0 at once; first edge after release loads the current reg[select].
REQ-027 With MUX32TO1_LOAD_EN: load_en=0, select moves 7→14 -> regout stays 7; load_en=1 -> regout = 14 next edge.
